passcode_checker: RTL

Holds the lock's entered and stored passcodes and compares them. It sits between the lock controller and the HEX display decoders:
- It consumes the controller's single-cycle `input_value` / `store_value` / `compare` / `input_reset` commands and the symbol switches.
- It produces the per-digit nibbles for the four displays and the `correct_password` / `incorrect_password` result pulses the controller branches on.
- It also counts consecutive failed attempts and locks out further entry after a fixed number of them.

---
 rtl/passcode_pkg.sv | 11 +
 rtl/digit_shift_reg.sv | 20 ++
 rtl/passcode_checker.sv | 79 +++++++
 3 files changed

// File: rtl/passcode_pkg.sv
// passcode_pkg: shared constants, entry-state enum and symbol type for the passcode checker
package passcode_pkg;
  localparam int PASS_LEN = 4;
  localparam int SYM_W_MAX = 4;
  localparam logic [3:0] BLANK = 4'h0;
  typedef logic [SYM_W_MAX-1:0] sym_t;
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} entry_state_t;
  function automatic entry_state_t state_of(input logic [2:0] n);
    return n == 3'd0 ? EMPTY : (n >= 3'(PASS_LEN) ? FULL : PARTIAL);
  endfunction
endpackage

// File: rtl/digit_shift_reg.sv
// digit_shift_reg: PASS_LEN-digit store with indexed write, parallel load, clear and parallel output
module digit_shift_reg import passcode_pkg::*; #(
  parameter int SYM_W = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            wr,
  input  logic                            load,
  input  logic [1:0]                      idx,
  input  logic [SYM_W-1:0]                din,
  input  logic [PASS_LEN-1:0][SYM_W-1:0]  load_data,
  output logic [PASS_LEN-1:0][SYM_W-1:0]  q
);
  always_ff @(posedge clk)
    for (int k = 0; k < PASS_LEN; k++)
      if (rst || clr) q[k] <= SYM_W'(BLANK);
      else if (load) q[k] <= load_data[k];
      else if (wr && idx == k[1:0]) q[k] <= din;
endmodule

// File: rtl/passcode_checker.sv
// passcode_checker: entry/stored passcode compare with fail lockout
// Optional PASSCODE_SHOW_STORED_EN adds show_stored to display the stored code.
module passcode_checker import passcode_pkg::*; #(
  parameter int SYM_W = 2,
  parameter int MAX_FAILS = 3
) (
  input  logic             clk,
  input  logic             system_reset,
  input  logic             input_reset,
  input  logic             input_value,
  input  logic             store_value,
  input  logic             compare,
  input  logic [SYM_W-1:0] bits,
`ifdef PASSCODE_SHOW_STORED_EN
  input  logic             show_stored,
`endif
  output logic [3:0]       reg0,
  output logic [3:0]       reg1,
  output logic [3:0]       reg2,
  output logic [3:0]       reg3,
  output logic             correct_password,
  output logic             incorrect_password,
  output logic             locked_out,
  output logic             stored_valid,
  output logic [2:0]       entry_count
);
  localparam int FW = $clog2(MAX_FAILS + 1);
  logic [FW-1:0] fails, fails_next;
  logic [PASS_LEN-1:0][SYM_W-1:0] entry, stored, disp;
  entry_state_t st;
  logic live, do_cmp, do_store, do_in, match;
  assign st = state_of(entry_count);
  // A raised compare blocks store/input in its cycle even when it is itself ignored
  assign live = !input_reset && !locked_out;
  assign do_cmp = live && compare && stored_valid;
  assign do_store = live && !compare && store_value && st == FULL;
  assign do_in = live && !compare && !store_value && input_value && st != FULL;
  assign match = st == FULL && entry == stored;
  assign fails_next = match ? '0 : (fails == FW'(MAX_FAILS) ? fails : fails + 1'b1);
  digit_shift_reg #(.SYM_W(SYM_W)) u_entry (
    .clk(clk), .rst(system_reset), .clr(input_reset || do_cmp || do_store),
    .wr(do_in), .load(1'b0), .idx(entry_count[1:0]), .din(bits),
    .load_data('0), .q(entry)
  );
  digit_shift_reg #(.SYM_W(SYM_W)) u_stored (
    .clk(clk), .rst(system_reset), .clr(1'b0),
    .wr(1'b0), .load(do_store), .idx(2'd0), .din('0),
    .load_data(entry), .q(stored)
  );
  always_ff @(posedge clk)
    if (system_reset) begin
      entry_count <= '0;
      stored_valid <= 1'b0;
      fails <= '0;
      locked_out <= 1'b0;
      correct_password <= 1'b0;
      incorrect_password <= 1'b0;
    end else begin
      correct_password <= do_cmp && match;
      incorrect_password <= do_cmp && !match;
      if (do_cmp) begin
        fails <= fails_next;
        locked_out <= fails_next == FW'(MAX_FAILS);
      end
      if (do_store) stored_valid <= 1'b1;
      entry_count <= (input_reset || do_cmp || do_store) ? 3'd0 : entry_count + 3'(do_in);
    end
`ifdef PASSCODE_SHOW_STORED_EN
  logic show_q;
  always_ff @(posedge clk) show_q <= system_reset ? 1'b0 : show_stored;
  assign disp = (show_q && !locked_out) ? stored : entry;
`else
  assign disp = entry;
`endif
  assign reg0 = 4'(disp[0]);
  assign reg1 = 4'(disp[1]);
  assign reg2 = 4'(disp[2]);
  assign reg3 = 4'(disp[3]);
endmodule
